// File: rtl/seven_seg_capture_if.sv
// Bus bundle for seven_seg_capture.
// Purpose : groups the scanned display inputs, the clear strobe and the recovered-digit outputs.
// Signals : anodes/cathodes/clear driven by the master (display side or bench);
//           hex_out/digit_valid/frame_done/decode_err (and digit_blank when BLANK_DETECT_EN
//           is defined) driven by the slave (the capture block).
interface seven_seg_capture_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [NUM_DIGITS-1:0]   anodes;
   logic [6:0]              cathodes;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] hex_out;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    frame_done;
   logic                    decode_err;
`ifdef BLANK_DETECT_EN
   logic [NUM_DIGITS-1:0]   digit_blank;
`endif

`ifdef BLANK_DETECT_EN
   modport master (output anodes, cathodes, clear,
                   input  hex_out, digit_valid, frame_done, decode_err, digit_blank);
   modport slave  (input  anodes, cathodes, clear,
                   output hex_out, digit_valid, frame_done, decode_err, digit_blank);
`else
   modport master (output anodes, cathodes, clear,
                   input  hex_out, digit_valid, frame_done, decode_err);
   modport slave  (input  anodes, cathodes, clear,
                   output hex_out, digit_valid, frame_done, decode_err);
`endif
endinterface

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Purpose : recovers the hex digit shown on each position of a multiplexed, active-low
//           7-segment bus. Samples are debounced, the 16 encoder patterns are decoded,
//           illegal patterns raise a sticky error and completed frames are pulsed.
// Ports   : clk      - rising-edge clock
//           reset_n  - asynchronous active-low reset
//           bus      - seven_seg_capture_if.slave (anodes, cathodes, clear in;
//                      hex_out, digit_valid, frame_done, decode_err [, digit_blank] out)
// Config  : BLANK_DETECT_EN - when defined, cathodes=1111111 is a legal blank and
//           digit_blank is driven; otherwise that pattern is illegal.
module seven_seg_capture #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   seven_seg_capture_if.slave   bus
);

   localparam int unsigned SW = NUM_DIGITS + 7;
   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned LW = $clog2(NUM_DIGITS + 1);

   typedef enum logic {SETTLING = 1'b0, HELD = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           samp_q, prev_q;
   logic [CW-1:0]           cnt_q;
   logic                    change_c, capture_c;
   logic [NUM_DIGITS-1:0]   an_s;
   logic [6:0]              cat_s;
   logic [LW-1:0]           low_cnt;
   logic [IW-1:0]           idx_c;
   logic                    one_c;
   logic                    legal_c, mark_c;
   logic [3:0]              val_c;
   logic [NUM_DIGITS-1:0]   sel_c, seen_set_c;
   logic [4*NUM_DIGITS-1:0] hex_q;
   logic [NUM_DIGITS-1:0]   valid_q, seen_q;
   logic                    frame_q, err_q;
`ifdef BLANK_DETECT_EN
   logic                    blank_c;
   logic [NUM_DIGITS-1:0]   blank_q;
`endif

   assign an_s     = samp_q[SW-1:7];
   assign cat_s    = samp_q[6:0];
   assign change_c = (samp_q != prev_q);

   // Input register plus one-deep history for change detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_q <= '0;
         prev_q <= '0;
      end else begin
         samp_q <= {bus.anodes, bus.cathodes};
         prev_q <= samp_q;
      end
   end

   // Stability counter, saturating
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           cnt_q <= '0;
      else if (change_c)                      cnt_q <= '0;
      else if (cnt_q != CW'(STABLE_CYCLES))   cnt_q <= cnt_q + CW'(1);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= SETTLING;
      else          state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         SETTLING: if (capture_c) state_d = HELD;
         HELD:     if (change_c)  state_d = SETTLING;
         default:                 state_d = SETTLING;
      endcase
   end

   // FSM output: capture on the edge where the counter reaches STABLE_CYCLES-1
   always_comb begin
      capture_c = 1'b0;
      if (state_q == SETTLING && !change_c && cnt_q == CW'(STABLE_CYCLES - 2))
         capture_c = 1'b1;
   end

   // Active anode: exactly one low bit selects the position
   always_comb begin
      low_cnt = '0;
      idx_c   = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (!an_s[i]) begin
            low_cnt = low_cnt + LW'(1);
            idx_c   = IW'(i);
         end
      end
      one_c = (low_cnt == LW'(1));
      sel_c        = '0;
      sel_c[idx_c] = 1'b1;
   end

   // Cathode pattern decode (inverse of the hex encoder)
   always_comb begin
      legal_c = 1'b1;
      val_c   = 4'h0;
      case (cat_s)
         7'b0000001: val_c = 4'h0;
         7'b1001111: val_c = 4'h1;
         7'b0010010: val_c = 4'h2;
         7'b0000110: val_c = 4'h3;
         7'b1001100: val_c = 4'h4;
         7'b0100100: val_c = 4'h5;
         7'b0100000: val_c = 4'h6;
         7'b0001111: val_c = 4'h7;
         7'b0000000: val_c = 4'h8;
         7'b0000100: val_c = 4'h9;
         7'b0001000: val_c = 4'hA;
         7'b1100000: val_c = 4'hB;
         7'b0110001: val_c = 4'hC;
         7'b1000010: val_c = 4'hD;
         7'b0110000: val_c = 4'hE;
         7'b0111000: val_c = 4'hF;
         default:    legal_c = 1'b0;
      endcase
   end

`ifdef BLANK_DETECT_EN
   assign blank_c = (cat_s == 7'h7F);
   assign mark_c  = legal_c | blank_c;
`else
   assign mark_c  = legal_c;
`endif
   assign seen_set_c = seen_q | (mark_c ? sel_c : '0);

   // Capture outputs; clear takes priority over a same-cycle capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_q   <= '0;
         valid_q <= '0;
         seen_q  <= '0;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef BLANK_DETECT_EN
         blank_q <= '0;
`endif
      end else begin
         frame_q <= 1'b0;
         if (bus.clear) begin
            hex_q   <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            err_q   <= 1'b0;
`ifdef BLANK_DETECT_EN
            blank_q <= '0;
`endif
         end else if (capture_c && one_c) begin
            if (legal_c) begin
               hex_q[{idx_c, 2'b00} +: 4] <= val_c;
               valid_q[idx_c]             <= 1'b1;
`ifdef BLANK_DETECT_EN
               blank_q[idx_c]             <= 1'b0;
            end else if (blank_c) begin
               valid_q[idx_c]             <= 1'b0;
               blank_q[idx_c]             <= 1'b1;
`endif
            end else begin
               valid_q[idx_c]             <= 1'b0;
               err_q                      <= 1'b1;
            end
            // A frame completes when every position has been seen; restart the mask
            if (&seen_set_c) begin
               frame_q <= 1'b1;
               seen_q  <= '0;
            end else begin
               seen_q  <= seen_set_c;
            end
         end
      end
   end

   assign bus.hex_out     = hex_q;
   assign bus.digit_valid = valid_q;
   assign bus.frame_done  = frame_q;
   assign bus.decode_err  = err_q;
`ifdef BLANK_DETECT_EN
   assign bus.digit_blank = blank_q;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
// Directed scenarios plus a randomized scan checked against a per-segment reference model.
module tb_seven_seg_capture;

   localparam int unsigned ND = 4;
   localparam int unsigned SC = 4;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   seven_seg_capture_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;
   int fd_count = 0;
   logic [10:0] last_pat = '0;

   // Reference model state, one entry per display position
   int m_digit [ND];
   bit m_valid [ND];
   bit m_seen  [ND];
   bit m_blank [ND];
   bit m_err;
   int m_frames;

   always @(negedge clk) if (bus.frame_done === 1'b1) fd_count++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   function automatic int decode(input logic [6:0] c);
      for (int i = 0; i < 16; i++) if (SEG_TAB[i] == c) return i;
      return -1;
   endfunction

   function automatic logic [15:0] exp_hex();
      logic [15:0] v;
      for (int i = 0; i < int'(ND); i++) v[4*i +: 4] = 4'(m_digit[i]);
      return v;
   endfunction

   function automatic logic [3:0] exp_valid();
      logic [3:0] v;
      for (int i = 0; i < int'(ND); i++) v[i] = m_valid[i];
      return v;
   endfunction

   function automatic logic [3:0] exp_blank();
      logic [3:0] v;
      for (int i = 0; i < int'(ND); i++) v[i] = m_blank[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < int'(ND); i++) begin
         m_digit[i] = 0; m_valid[i] = 0; m_seen[i] = 0; m_blank[i] = 0;
      end
      m_err = 0;
   endtask

   // A pattern held long enough is captured once
   task automatic model_capture(input logic [3:0] an, input logic [6:0] cat);
      int lows, pos, v;
      bit all;
      lows = 0; pos = 0;
      for (int i = 0; i < int'(ND); i++) if (!an[i]) begin lows++; pos = i; end
      if (lows != 1) return;
      v = decode(cat);
      if (v >= 0) begin
         m_digit[pos] = v; m_valid[pos] = 1; m_seen[pos] = 1; m_blank[pos] = 0;
`ifdef BLANK_DETECT_EN
      end else if (cat == 7'h7F) begin
         m_valid[pos] = 0; m_seen[pos] = 1; m_blank[pos] = 1;
`endif
      end else begin
         m_err = 1; m_valid[pos] = 0;
      end
      all = 1;
      for (int i = 0; i < int'(ND); i++) all &= m_seen[i];
      if (all) begin
         m_frames++;
         for (int i = 0; i < int'(ND); i++) m_seen[i] = 0;
      end
   endtask

   // Present a pattern at a falling edge and hold it for h cycles
   task automatic drive(input logic [3:0] an, input logic [6:0] cat, input int h);
      bus.anodes   = an;
      bus.cathodes = cat;
      last_pat     = {an, cat};
      repeat (h) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      bus.anodes   = 4'hF;
      bus.cathodes = 7'h7F;
      bus.clear    = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.hex_out !== 16'h0) begin errors++; $display("FAIL reset_hex: got %h want 0000", bus.hex_out); end
      checks++; if (bus.digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b want 0000", bus.digit_valid); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", bus.frame_done); end
      checks++; if (bus.decode_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.decode_err); end
      reset_n = 1'b1;
   endtask

   task automatic test_scan();
      int fd0, fd_cycle;
      drive(4'b1110, 7'b1001111, 10);
      drive(4'b1101, 7'b0010010, 10);
      drive(4'b1011, 7'b0001000, 10);
      checks++; if (fd_count !== 0) begin errors++; $display("FAIL scan_early_frame: got %0d pulses want 0", fd_count); end
      fd0 = fd_count; fd_cycle = -1;
      bus.anodes = 4'b0111; bus.cathodes = 7'b0111000; last_pat = {4'b0111, 7'b0111000};
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.frame_done === 1'b1 && fd_cycle < 0) fd_cycle = c;
      end
      checks++; if (bus.hex_out !== 16'hFA21) begin errors++; $display("FAIL scan_hex: got %h want fa21", bus.hex_out); end
      checks++; if (bus.digit_valid !== 4'hF) begin errors++; $display("FAIL scan_valid: got %b want 1111", bus.digit_valid); end
      checks++; if (fd_count - fd0 !== 1) begin errors++; $display("FAIL scan_frame_count: got %0d want 1", fd_count - fd0); end
      checks++; if (fd_cycle !== int'(SC) + 1) begin errors++; $display("FAIL scan_frame_latency: got cycle %0d want %0d", fd_cycle, SC + 1); end
      checks++; if (bus.decode_err !== 1'b0) begin errors++; $display("FAIL scan_err: got %b want 0", bus.decode_err); end
   endtask

   task automatic test_glitch();
      int fd0;
      fd0 = fd_count;
      drive(4'b1110, 7'b0000000, SC - 1);
      drive(4'b1111, 7'h7F, 10);
      checks++; if (bus.hex_out !== 16'hFA21) begin errors++; $display("FAIL glitch_short_hex: got %h want fa21", bus.hex_out); end
      checks++; if (bus.digit_valid !== 4'hF) begin errors++; $display("FAIL glitch_short_valid: got %b want 1111", bus.digit_valid); end
      drive(4'b1110, 7'b0000000, SC);
      drive(4'b1111, 7'h7F, 10);
      checks++; if (bus.hex_out !== 16'hFA28) begin errors++; $display("FAIL glitch_exact_hex: got %h want fa28", bus.hex_out); end
      checks++; if (fd_count !== fd0) begin errors++; $display("FAIL glitch_frame: got %0d pulses want 0", fd_count - fd0); end
   endtask

   task automatic test_illegal();
      drive(4'b1101, 7'b1111110, 10);
      checks++; if (bus.decode_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", bus.decode_err); end
      checks++; if (bus.digit_valid !== 4'b1101) begin errors++; $display("FAIL illegal_valid: got %b want 1101", bus.digit_valid); end
      checks++; if (bus.hex_out !== 16'hFA28) begin errors++; $display("FAIL illegal_hex: got %h want fa28", bus.hex_out); end
      drive(4'b0111, 7'b0000110, 10);
      checks++; if (bus.decode_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", bus.decode_err); end
      checks++; if (bus.hex_out !== 16'h3A28) begin errors++; $display("FAIL illegal_next_hex: got %h want 3a28", bus.hex_out); end
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      checks++; if (bus.decode_err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b want 0", bus.decode_err); end
      checks++; if (bus.digit_valid !== 4'h0) begin errors++; $display("FAIL clear_valid: got %b want 0000", bus.digit_valid); end
      checks++; if (bus.hex_out !== 16'h0) begin errors++; $display("FAIL clear_hex: got %h want 0000", bus.hex_out); end
   endtask

   task automatic test_multi_anode();
      drive(4'b1110, 7'b0100100, 10);
      checks++; if (bus.hex_out !== 16'h0005) begin errors++; $display("FAIL multi_setup_hex: got %h want 0005", bus.hex_out); end
      drive(4'b1100, 7'b0000000, 20);
      checks++; if (bus.hex_out !== 16'h0005 || bus.digit_valid !== 4'b0001) begin
         errors++; $display("FAIL multi_two_low: got %h/%b want 0005/0001", bus.hex_out, bus.digit_valid); end
      drive(4'b1111, 7'b0000000, 20);
      checks++; if (bus.hex_out !== 16'h0005 || bus.digit_valid !== 4'b0001 || bus.decode_err !== 1'b0) begin
         errors++; $display("FAIL multi_none_low: got %h/%b/%b want 0005/0001/0", bus.hex_out, bus.digit_valid, bus.decode_err); end
   endtask

   task automatic test_clear_capture();
      bus.anodes = 4'b1011; bus.cathodes = 7'b0001111; last_pat = {4'b1011, 7'b0001111};
      repeat (SC) @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      checks++; if (bus.digit_valid !== 4'h0) begin errors++; $display("FAIL clear_wins_valid: got %b want 0000", bus.digit_valid); end
      checks++; if (bus.hex_out !== 16'h0) begin errors++; $display("FAIL clear_wins_hex: got %h want 0000", bus.hex_out); end
      repeat (6) @(negedge clk);
      checks++; if (bus.digit_valid !== 4'h0) begin errors++; $display("FAIL clear_no_recapture: got %b want 0000", bus.digit_valid); end
   endtask

   task automatic test_blank();
      drive(4'b1110, 7'h7F, 10);
`ifdef BLANK_DETECT_EN
      checks++; if (bus.digit_blank !== 4'b0001) begin errors++; $display("FAIL blank_flag: got %b want 0001", bus.digit_blank); end
      checks++; if (bus.decode_err !== 1'b0) begin errors++; $display("FAIL blank_err: got %b want 0", bus.decode_err); end
      drive(4'b1110, 7'b1001111, 10);
      checks++; if (bus.digit_blank !== 4'b0000) begin errors++; $display("FAIL blank_cleared: got %b want 0000", bus.digit_blank); end
`else
      checks++; if (bus.decode_err !== 1'b1) begin errors++; $display("FAIL blank_illegal_err: got %b want 1", bus.decode_err); end
`endif
      checks++; if (bus.digit_valid[0] !== 1'b0 && bus.hex_out[3:0] !== 4'h1) begin
         errors++; $display("FAIL blank_pos0: got valid %b hex %h", bus.digit_valid[0], bus.hex_out[3:0]); end
   endtask

   task automatic test_random();
      logic [3:0] an;
      logic [6:0] cat;
      int h, r, fd0;
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      model_clear();
      m_frames = 0;
      fd0 = fd_count;
      for (int s = 0; s < 150; s++) begin
         do begin
            if ($urandom_range(0, 3) != 0) an = ~(4'b0001 << $urandom_range(0, 3));
            else                           an = 4'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 7)       cat = SEG_TAB[$urandom_range(0, 15)];
            else if (r == 7) cat = 7'h7F;
            else             cat = 7'($urandom);
         end while ({an, cat} == last_pat);
         if ($urandom_range(0, 2) == 0) h = int'($urandom_range(1, SC - 1));
         else                           h = int'($urandom_range(SC + 1, SC + 6));
         if ($urandom_range(0, 11) == 0) begin
            bus.clear = 1'b1;
            model_clear();
            drive(an, cat, 1);
            bus.clear = 1'b0;
            if (h > 1) repeat (h - 1) @(negedge clk);
         end else begin
            drive(an, cat, h);
         end
         if (h > int'(SC)) model_capture(an, cat);
         checks++; if (bus.hex_out !== exp_hex()) begin errors++; $display("FAIL rand_hex[%0d]: got %h want %h", s, bus.hex_out, exp_hex()); end
         checks++; if (bus.digit_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", s, bus.digit_valid, exp_valid()); end
         checks++; if (bus.decode_err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", s, bus.decode_err, m_err); end
`ifdef BLANK_DETECT_EN
         checks++; if (bus.digit_blank !== exp_blank()) begin errors++; $display("FAIL rand_blank[%0d]: got %b want %b", s, bus.digit_blank, exp_blank()); end
`endif
      end
      checks++; if (fd_count - fd0 !== m_frames) begin errors++; $display("FAIL rand_frames: got %0d want %0d", fd_count - fd0, m_frames); end
   endtask

   task automatic test_reset_mid();
      drive(4'b0011, 7'b0000000, 3);
      drive(4'b1110, 7'b1001111, 10);
      checks++; if (bus.digit_valid[0] !== 1'b1) begin errors++; $display("FAIL midrst_setup: got %b want 1", bus.digit_valid[0]); end
      bus.anodes = 4'b1101; bus.cathodes = 7'b0000100; last_pat = {4'b1101, 7'b0000100};
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.hex_out !== 16'h0 || bus.digit_valid !== 4'h0 || bus.decode_err !== 1'b0 || bus.frame_done !== 1'b0) begin
         errors++; $display("FAIL midrst_async: got %h/%b/%b/%b want 0000/0000/0/0", bus.hex_out, bus.digit_valid, bus.decode_err, bus.frame_done); end
      @(negedge clk);
      checks++; if (bus.hex_out !== 16'h0 || bus.digit_valid !== 4'h0) begin
         errors++; $display("FAIL midrst_held: got %h/%b want 0000/0000", bus.hex_out, bus.digit_valid); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.digit_valid !== 4'h0) begin errors++; $display("FAIL midrst_no_partial: got %b want 0000", bus.digit_valid); end
      repeat (SC) @(negedge clk);
      checks++; if (bus.digit_valid !== 4'b0010 || bus.hex_out !== 16'h0090) begin
         errors++; $display("FAIL midrst_recapture: got %b/%h want 0010/0090", bus.digit_valid, bus.hex_out); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_glitch();
      test_illegal();
      test_multi_anode();
      test_clear_capture();
      test_blank();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
